// File: rtl/vga_timing_pkg.sv
// XGA timing constants and derived window bounds shared by the timing generator,
// the draw stages and the mouse-to-cell mapper.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 11;

  localparam int unsigned H_ACTIVE = 1024;
  localparam int unsigned H_FP     = 24;
  localparam int unsigned H_SYNC   = 136;
  localparam int unsigned H_BP     = 160;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 768;
  localparam int unsigned V_FP     = 3;
  localparam int unsigned V_SYNC   = 6;
  localparam int unsigned V_BP     = 29;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Inclusive window bounds, in counter units
  localparam int unsigned H_BLNK_START = H_ACTIVE;
  localparam int unsigned H_BLNK_END   = H_TOTAL - 1;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned V_BLNK_START = V_ACTIVE;
  localparam int unsigned V_BLNK_END   = V_TOTAL - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC - 1;

  // Timing bus as forwarded between draw stages
  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic             hsync;
    logic             hblnk;
    logic [CNT_W-1:0] vcount;
    logic             vsync;
    logic             vblnk;
  } vga_bus_t;

  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One timing axis: mod-TOTAL counter with sync/blank flags registered from the
// next count so that count and flags always describe the same position.
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE,
  parameter int unsigned FP     = H_FP,
  parameter int unsigned SYNC   = H_SYNC,
  parameter int unsigned BP     = H_BP
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             sync,
  output logic             blnk,
  output logic             wrap_c
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] BLNK_START = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC - 1);

  logic [CNT_W-1:0] count_next_c;

  assign wrap_c = en && (count == LAST);

  always_comb begin
    count_next_c = count;
    if (wrap_c) begin
      count_next_c = '0;
    end else if (en) begin
      count_next_c = count + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      count <= '0;
      sync  <= 1'b0;
      blnk  <= 1'b0;
    end else begin
      count <= count_next_c;
      sync  <= in_window(count_next_c, SYNC_START, SYNC_END);
      blnk  <= in_window(count_next_c, BLNK_START, LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Source of the VGA timing bus: free-running h/v counters, sync/blank flags and a
// frame_start strobe, all registered and describing the same pixel.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned P_H_ACTIVE = H_ACTIVE,
  parameter int unsigned P_H_FP     = H_FP,
  parameter int unsigned P_H_SYNC   = H_SYNC,
  parameter int unsigned P_H_BP     = H_BP,
  parameter int unsigned P_V_ACTIVE = V_ACTIVE,
  parameter int unsigned P_V_FP     = V_FP,
  parameter int unsigned P_V_SYNC   = V_SYNC,
  parameter int unsigned P_V_BP     = V_BP
) (
  input  logic             pclk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic             frame_start
);

  logic h_wrap_c;
  logic v_wrap_c;

  timing_axis #(
    .ACTIVE (P_H_ACTIVE),
    .FP     (P_H_FP),
    .SYNC   (P_H_SYNC),
    .BP     (P_H_BP)
  ) u_h_axis (
    .pclk   (pclk),
    .rst    (rst),
    .en     (1'b1),
    .count  (hcount_out),
    .sync   (hsync_out),
    .blnk   (hblnk_out),
    .wrap_c (h_wrap_c)
  );

  // Vertical axis steps once per line, on the horizontal wrap
  timing_axis #(
    .ACTIVE (P_V_ACTIVE),
    .FP     (P_V_FP),
    .SYNC   (P_V_SYNC),
    .BP     (P_V_BP)
  ) u_v_axis (
    .pclk   (pclk),
    .rst    (rst),
    .en     (h_wrap_c),
    .count  (vcount_out),
    .sync   (vsync_out),
    .blnk   (vblnk_out),
    .wrap_c (v_wrap_c)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= v_wrap_c;
    end
  end

endmodule
